// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder
//
// Finds the 12-bit data-processing immediate field {rot, imm8} for a 32-bit
// constant, so that value == ROR(zero-extend(imm8), 2*rot). The search tries
// one rotation per cycle, starting at rot=0, so the smallest matching rot wins.
//
// Parameters:
//   MAX_ROT  highest rot value searched (0..15); larger rotations count as
//            not encodable
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse, only accepted while ready is high
//   value    constant to encode, captured when start is accepted
//   ready    high in IDLE
//   busy     high in SEARCH and DONE
//   done     one-cycle pulse when found/shifter are valid
//   found    1 = encodable; holds until the next accepted start
//   shifter  {rot, imm8} when found, else 12'h000; holds like found

module imm_operand_encoder #(
  parameter int unsigned MAX_ROT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shifter
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } stateT;

  localparam logic [3:0] MaxRot = 4'(MAX_ROT);

  stateT       state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic        found_q, found_d;
  logic [11:0] shifter_q, shifter_d;

  logic [5:0]  rotAmt;
  logic [31:0] candidate;
  logic        hit;
  logic        lastRot;

  // Rotating the constant left by 2*rot undoes the decoder's right rotation;
  // if what lands in the low byte is all there is, that byte is imm8.
  // With rotAmt=0 the right shift is by 32 and contributes nothing.
  assign rotAmt    = {1'b0, rot_q, 1'b0};
  assign candidate = (value_q << rotAmt) | (value_q >> (6'd32 - rotAmt));
  assign hit       = (candidate[31:8] == 24'd0);
  assign lastRot   = (rot_q == MaxRot);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: captured constant, rotation counter and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q     <= 4'd0;
      value_q   <= 32'd0;
      found_q   <= 1'b0;
      shifter_q <= 12'h000;
    end else begin
      rot_q     <= rot_d;
      value_q   <= value_d;
      found_q   <= found_d;
      shifter_q <= shifter_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    rot_d     = rot_q;
    value_d   = value_q;
    found_d   = found_q;
    shifter_d = shifter_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          value_d   = value;
          rot_d     = 4'd0;
          found_d   = 1'b0;
          shifter_d = 12'h000;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          found_d   = 1'b1;
          shifter_d = {rot_q, candidate[7:0]};
          state_d   = DONE;
        end else if (lastRot) begin
          found_d   = 1'b0;
          shifter_d = 12'h000;
          state_d   = DONE;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    ready   = (state_q == IDLE);
    busy    = (state_q == SEARCH) || (state_q == DONE);
    done    = (state_q == DONE);
    found   = found_q;
    shifter = shifter_q;
  end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// tb_imm_operand_encoder
//
// Directed and randomized checks of imm_operand_encoder. Two instances are
// used: one with the full rotation range and one limited to MAX_ROT=3.

module tb_imm_operand_encoder;

  logic        clk;
  logic        rst_n;
  logic        start15;
  logic        start3;
  logic [31:0] value;

  logic        ready15, busy15, done15, found15;
  logic [11:0] shifter15;
  logic        ready3, busy3, done3, found3;
  logic [11:0] shifter3;

  int vectorCount = 0;
  int missCount   = 0;

  imm_operand_encoder #(.MAX_ROT(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start15),
    .value   (value),
    .ready   (ready15),
    .busy    (busy15),
    .done    (done15),
    .found   (found15),
    .shifter (shifter15)
  );

  imm_operand_encoder #(.MAX_ROT(3)) dutSmall (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start3),
    .value   (value),
    .ready   (ready3),
    .busy    (busy3),
    .done    (done3),
    .found   (found3),
    .shifter (shifter3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports a miscompare
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference: try each rot in order and accept the first whose decode
  // reproduces the constant exactly.
  task automatic refEncode(input logic [31:0] v, input int maxRot,
                           output logic expFound, output logic [11:0] expShifter,
                           output int expLatency);
    expFound   = 1'b0;
    expShifter = 12'h000;
    expLatency = maxRot + 1;
    for (int r = 0; r <= maxRot; r++) begin
      for (int imm = 0; imm < 256; imm++) begin
        if (ror32(32'(imm), 2 * r) == v) begin
          expFound   = 1'b1;
          expShifter = {4'(r), 8'(imm)};
          expLatency = r + 1;
          return;
        end
      end
    end
  endtask

  // Waits for ready, issues one request and waits (bounded) for done.
  // With disturb set, start is reasserted and value changed mid-search.
  task automatic applyStimulus(input bit useSmall, input logic [31:0] v,
                               input bit disturb, output logic gotFound,
                               output logic [11:0] gotShifter, output int latency);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!(useSmall ? ready3 : ready15) && waitCycles < 40) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 40) checkOutput("readyTimeout", 32'd0, 32'd1);
    value = v;
    if (useSmall) start3 = 1'b1;
    else start15 = 1'b1;
    @(posedge clk);
    #1;
    start15 = 1'b0;
    start3  = 1'b0;
    latency = 0;
    while (latency < 40) begin
      if (disturb && latency == 1) begin
        start15 = 1'b1;
        value   = 32'h000000FF;
      end
      @(posedge clk);
      latency++;
      #1;
      if (disturb && latency == 2) begin
        start15 = 1'b0;
        checkOutput("busyInSearch", 32'(busy15), 32'd1);
        checkOutput("notReadyInSearch", 32'(ready15), 32'd0);
      end
      if (useSmall ? done3 : done15) break;
    end
    if (!(useSmall ? done3 : done15)) checkOutput("doneTimeout", 32'd0, 32'd1);
    gotFound   = useSmall ? found3 : found15;
    gotShifter = useSmall ? shifter3 : shifter15;
  endtask

  logic        gotFound, expFound;
  logic [11:0] gotShifter, expShifter;
  int          latency, expLatency;
  logic [31:0] randValue;
  logic        sawDone;

  initial begin
    rst_n   = 1'b0;
    start15 = 1'b0;
    start3  = 1'b0;
    value   = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("resetReady", 32'(ready15), 32'd1);
    checkOutput("resetBusy", 32'(busy15), 32'd0);
    checkOutput("resetDone", 32'(done15), 32'd0);
    checkOutput("resetFound", 32'(found15), 32'd0);
    checkOutput("resetShifter", 32'(shifter15), 32'h000);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results
    applyStimulus(1'b0, 32'h000000FF, 1'b0, gotFound, gotShifter, latency);
    checkOutput("ffFound", 32'(gotFound), 32'd1);
    checkOutput("ffShifter", 32'(gotShifter), 32'h0FF);
    checkOutput("ffLatency", 32'(latency), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("donePulseOneCycle", 32'(done15), 32'd0);
    checkOutput("readyAfterDone", 32'(ready15), 32'd1);
    checkOutput("foundHolds", 32'(found15), 32'd1);

    applyStimulus(1'b0, 32'hFF000000, 1'b0, gotFound, gotShifter, latency);
    checkOutput("topByteFound", 32'(gotFound), 32'd1);
    checkOutput("topByteShifter", 32'(gotShifter), 32'h4FF);
    checkOutput("topByteLatency", 32'(latency), 32'd5);

    applyStimulus(1'b0, 32'hF000000F, 1'b0, gotFound, gotShifter, latency);
    checkOutput("wrapFound", 32'(gotFound), 32'd1);
    checkOutput("wrapShifter", 32'(gotShifter), 32'h2FF);
    checkOutput("wrapLatency", 32'(latency), 32'd3);

    applyStimulus(1'b0, 32'h00000101, 1'b0, gotFound, gotShifter, latency);
    checkOutput("noEncFound", 32'(gotFound), 32'd0);
    checkOutput("noEncShifter", 32'(gotShifter), 32'h000);
    checkOutput("noEncLatency", 32'(latency), 32'd16);

    applyStimulus(1'b1, 32'hFF000000, 1'b0, gotFound, gotShifter, latency);
    checkOutput("maxRot3Found", 32'(gotFound), 32'd0);
    checkOutput("maxRot3Shifter", 32'(gotShifter), 32'h000);
    checkOutput("maxRot3Latency", 32'(latency), 32'd4);

    applyStimulus(1'b0, 32'hFF000000, 1'b1, gotFound, gotShifter, latency);
    checkOutput("ignoreFound", 32'(gotFound), 32'd1);
    checkOutput("ignoreShifter", 32'(gotShifter), 32'h4FF);
    checkOutput("ignoreLatency", 32'(latency), 32'd5);

    applyStimulus(1'b0, 32'h00000000, 1'b0, gotFound, gotShifter, latency);
    checkOutput("zeroFound", 32'(gotFound), 32'd1);
    checkOutput("zeroShifter", 32'(gotShifter), 32'h000);
    checkOutput("zeroLatency", 32'(latency), 32'd1);

    // Reset dropped mid-search must clear state without waiting for a clock
    @(negedge clk);
    value   = 32'h00000101;
    start15 = 1'b1;
    @(posedge clk);
    #1;
    start15 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortReady", 32'(ready15), 32'd1);
    checkOutput("abortBusy", 32'(busy15), 32'd0);
    checkOutput("abortDone", 32'(done15), 32'd0);
    checkOutput("abortFound", 32'(found15), 32'd0);
    checkOutput("abortShifter", 32'(shifter15), 32'h000);
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | done15;
    end
    checkOutput("abortNoDone", 32'(sawDone), 32'd0);

    // Random constants: half built from a legal encoding, half arbitrary
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 1) randValue = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      else randValue = $urandom;
      refEncode(randValue, 15, expFound, expShifter, expLatency);
      applyStimulus(1'b0, randValue, 1'b0, gotFound, gotShifter, latency);
      checkOutput("randFound", 32'(gotFound), 32'(expFound));
      checkOutput("randShifter", 32'(gotShifter), 32'(expShifter));
      checkOutput("randLatency", 32'(latency), 32'(expLatency));
      if (expFound) begin
        checkOutput("randRoundTrip",
                    ror32(32'(gotShifter[7:0]), 2 * int'(gotShifter[11:8])), randValue);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/imm_operand_encoder.md
Name: imm_operand_encoder

Overview:
- Iterative inverse of the data-processing immediate decode. Given a 32-bit constant, it searches for the 12-bit immediate shifter field {rot[3:0], imm8[7:0]} such that value == ROR(zero-extend(imm8), 2*rot).
- Used by the instruction-generation and assembler-support path to test whether a constant is encodable as an I=1 operand.
- Searches one rotation per cycle and returns the smallest matching rot.

Parameters:
- MAX_ROT, 15: highest rot value searched. Legal range 0..15. With a value below 15, larger rotations are treated as not encodable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- value  input  32  constant to encode; captured when start is accepted
- ready  output  1  high in IDLE (start will be accepted)
- busy  output  1  high in SEARCH and DONE
- done  output  1  one-cycle pulse when the result is valid
- found  output  1  1 = encodable, 0 = not encodable; holds until the next accepted start
- shifter  output  12  {rot, imm8} when found=1; 12'h000 when found=0; holds like found

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rot counter=0, captured value=0.
  - done=0, found=0, shifter=0, busy=0, ready=1.
  - Reset asserted mid-search aborts the search immediately; no done pulse is produced.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at an edge: capture value, rot<=0, found<=0, shifter<=0, go to SEARCH.
  - start=0: stay in IDLE.
- SEARCH, one rot per cycle:
  - Combinational candidate = ROL(captured value, 2*rot). This is a 32-bit rotate with wrap-around; rot=0 means no rotation.
  - Hit when candidate[31:8]==0.
  - On hit: shifter<={rot, candidate[7:0]}, found<=1, go to DONE.
  - On miss with rot==MAX_ROT: found<=0, shifter<=0, go to DONE.
  - On miss otherwise: rot<=rot+1, stay in SEARCH.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency:
  - Start is sampled at edge N and the hit is at rot k: done is high during the cycle after edge N+k+1.
  - Best case, rot 0: done is high during the cycle after edge N+1.
  - Not encodable with MAX_ROT=15: done is high during the cycle after edge N+16.
- start while busy (SEARCH or DONE) is ignored. No queuing. The captured value does not change.
- A change on the value input after capture has no effect on the running search.
- Multiple encodings exist for some constants (e.g. 0, or values with trailing zero pairs). The smallest rot always wins, so the result is deterministic.
- value==0 encodes as rot=0, imm8=0, giving shifter=12'h000 with found=1. found is what distinguishes this from a not-encodable result.
- Back-to-back operation: start may be asserted in the IDLE cycle immediately following DONE. The minimum request spacing is 3 cycles.
- Round-trip property: when found=1, decoding shifter with the I=1 rule (imm8 rotated right by 2*rot) must reproduce the captured value exactly.

Test Plan:
- Reset then start with value=32'h000000FF -> done during the cycle after edge N+1; found=1, shifter=12'h0FF.
- value=32'hFF000000 -> hit at rot=4; done after edge N+5; shifter=12'h4FF, found=1.
- value=32'hF000000F, a wrap-around case -> rot=2; shifter=12'h2FF, found=1; rot 1 must not match.
- value=32'h00000101, not encodable -> 16 SEARCH cycles, done after edge N+16, found=0, shifter=12'h000. Also with MAX_ROT=3, value=32'hFF000000 -> found=0 after 4 search cycles.
- Busy and zero handling:
  - Assert start again and change value during SEARCH -> both ignored; result matches the original value.
  - value=0 -> found=1, shifter=12'h000, at minimum latency.
- Reset and randomized check:
  - Drop rst_n for 1 cycle mid-search with value=32'h00000101 -> outputs cleared asynchronously, no done pulse, ready=1.
  - Then 1000 random values checked against the round-trip and smallest-rot reference model.
